fracnet_mul_share_sched: RTL and testbench
==========================================

// Module: fracnet_mul_share_sched
// PURPOSE
// - Time-shares one signed 16x12 DSP48 multiplier among NUM_REQ requesters (conv-layer scale/bias units).
// - Round-robin arbitration with per-requester valid/ready handshakes.
// - MUL_LAT-stage multiply pipeline; results return tagged with the requester id.
// - A single downstream ready stalls the whole pipeline.
// PARAMETERS
// - NUM_REQ  4   number of requesters (2..8)
// - A_W      16  signed operand A width
// - B_W      12  signed operand B width
// - P_W      28  product width; must equal A_W+B_W (elaboration error otherwise)
// - MUL_LAT  2   accept-to-result latency in cycles (2..4)
// - ID_W     2   requester id width = clog2(NUM_REQ)
// PORTS
// - ap_clk     in   1            clock, rising edge
// - ap_rst_n   in   1            asynchronous active-low reset
// - req_valid  in   NUM_REQ      per-requester operand valid
// - req_ready  out  NUM_REQ      per-requester accept; one-hot or zero
// - req_a      in   NUM_REQ*A_W  flattened signed A operands; slice i = [i*A_W +: A_W]
// - req_b      in   NUM_REQ*B_W  flattened signed B operands
// - rsp_valid  out  1            result valid
// - rsp_ready  in   1            downstream accepts result
// - rsp_p      out  P_W          signed product
// - rsp_id     out  ID_W         requester index of rsp_p
// - busy       out  1            any pipeline stage holds a valid op
// BEHAVIOUR
// - Reset values (async assert, sync-safe deassert):
//   - rsp_valid=0, rsp_p=0, rsp_id=0, busy=0, req_ready=0.
//   - All stage valid bits 0; rr pointer = 0.
// - Pipeline advance: adv = !rsp_valid | rsp_ready.
//   - When adv=0, every stage holds and req_ready=0.
//   - rsp_p, rsp_id and rsp_valid stay stable until accepted.
// - Arbitration: combinational.
//   - When adv=1, grant the first i with req_valid[i]=1, searching from ptr, ptr+1, ... modulo NUM_REQ.
//   - req_ready[i]=1 only for the granted i.
//   - A transfer occurs when req_valid[i] & req_ready[i].
// - Pointer update: on transfer from i, ptr <= (i+1) mod NUM_REQ, with wrap at NUM_REQ-1 -> 0.
//   - No transfer: ptr holds.
// - Requester rules:
//   - Must hold valid and operands stable until ready.
//   - May not withdraw valid. A bench checker flags a withdrawal; the design behaviour is then undefined.
// - Stages:
//   - s0 registers a, b and id on transfer.
//   - Middle stages carry the signed product a*b (full P_W, no saturation/rounding) plus id and valid.
//   - The last stage drives rsp_*.
//   - An op accepted at cycle t (no stalls) gives rsp_valid=1 at t+MUL_LAT.
// - Throughput: 1 op/cycle with continuous rsp_ready=1. Bubbles propagate as valid=0.
// - Simultaneous events:
//   - When a result is accepted in the same cycle a new op is granted, both occur (adv=1).
//   - A stall in the same cycle as req_valid rises: no grant, ptr unchanged.
// - busy = OR of all stage valid bits, including the output stage.
// - Reset mid-operation discards in-flight ops. No results emerge after reset release until new transfers occur.
// - Arithmetic: rsp_p = $signed(a)*$signed(b).
//   - Extremes: -32768 * -2048 = 67108864, which fits 28-bit signed.
// STRUCTURE
// - Package fracnet_mul_pkg:
//   - A_W, B_W, P_W localparams
//   - mul_op_t struct {a, b, id, vld}
//   - clog2 function
// - Sub-module fracnet_rr_arb:
//   - Parameterised NUM_REQ round-robin arbiter.
//   - Inputs: req vector, ptr, enable. Outputs: one-hot grant and encoded index.
//   - Pure combinational; ptr register lives in the parent.
// - Multiplier written as an inferred signed product in the pipeline for DSP48 mapping. No separate wrapper.
// TESTING
// - T1 single op: req0 a=3,b=-5 at t -> req_ready[0]=1 at t; rsp_valid at t+2, rsp_p=-15, rsp_id=0.
// - T2 fairness: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... and rsp_id sequence identical, 1 result/cycle.
// - T3 stall: rsp_ready=0 for 5 cycles with pipeline full -> rsp_p/rsp_id stable, req_ready=0 throughout, ptr unchanged, no op lost or duplicated.
// - T4 wrap/skip: only req3 and req1 valid, ptr=2 -> grant 3 then 1 (wrap), ptr ends at 2.
// - T5 extremes: a=-32768,b=-2048 -> 67108864; a=32767,b=-2048 -> -67106816; a=0,b=2047 -> 0.
// - T6 reset mid-flight: assert ap_rst_n=0 with 2 ops in flight -> rsp_valid=0 and busy=0 immediately, no stale results after release.

Source files
------------

// File: rtl/fracnet_mul_pkg.sv
// -----------------------------------------------------------------------------
// fracnet_mul_pkg
// Shared types and constants for the time-shared scale/bias multiplier.
//   A_W, B_W, P_W : native operand/product widths of the shared DSP48 slice
//   MAX_ID_W      : widest requester id the operand stage can carry (8 reqs)
//   mul_op_t      : operand-stage record {a, b, id, vld}
//   clog2         : elaboration-time ceil(log2) helper for id widths
// -----------------------------------------------------------------------------
package fracnet_mul_pkg;

   localparam int A_W      = 16;
   localparam int B_W      = 12;
   localparam int P_W      = A_W + B_W;
   localparam int MAX_ID_W = 3;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   typedef struct packed {
      logic signed [A_W-1:0]  a;
      logic signed [B_W-1:0]  b;
      logic [MAX_ID_W-1:0]    id;
      logic                   vld;
   } mul_op_t;

endpackage

// File: rtl/fracnet_rr_arb.sv
// -----------------------------------------------------------------------------
// fracnet_rr_arb
// Combinational round-robin arbiter. Searches req starting at ptr and wrapping
// modulo NUM_REQ; the first asserted request wins. The pointer register lives
// in the parent so it can be advanced only on a completed handshake.
//   req : request vector            ptr : search start index
//   en  : grant enable              gnt : one-hot grant (zero when none)
//   idx : encoded index of the grant (0 when none)
// -----------------------------------------------------------------------------
module fracnet_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx
);

   logic            found;
   int              j;
   logic [ID_W-1:0] jj;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr is always < NUM_REQ, so a single subtraction completes the wrap
         j = int'(ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         jj = ID_W'(j);
         if (en && !found && req[jj]) begin
            found   = 1'b1;
            gnt[jj] = 1'b1;
            idx     = jj;
         end
      end
   end

endmodule

// File: rtl/fracnet_mul_share_sched.sv
// -----------------------------------------------------------------------------
// fracnet_mul_share_sched
// Shares one signed A_W x B_W multiplier among NUM_REQ requesters. Operands are
// granted round-robin, registered in an operand stage, multiplied, and carried
// through MUL_LAT-1 product stages; the last stage drives the response. A single
// downstream ready stalls the whole pipeline.
//   ap_clk, ap_rst_n       : clock / asynchronous active-low reset
//   req_valid/req_ready    : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b           : flattened signed operands, slice i per requester
//   rsp_valid/rsp_ready    : response handshake
//   rsp_p, rsp_id          : signed product and the requester it belongs to
//   busy                   : any stage holds a valid op
// -----------------------------------------------------------------------------
module fracnet_mul_share_sched
   import fracnet_mul_pkg::mul_op_t;
   import fracnet_mul_pkg::clog2;
#(
   parameter int NUM_REQ = 4,
   parameter int A_W     = 16,
   parameter int B_W     = 12,
   parameter int P_W     = 28,
   parameter int MUL_LAT = 2,
   parameter int ID_W    = clog2(NUM_REQ)
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [P_W-1:0]         rsp_p,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
);

   if (P_W != A_W + B_W) begin : g_bad_pw
      $error("fracnet_mul_share_sched: P_W must equal A_W+B_W");
   end
   if (A_W != fracnet_mul_pkg::A_W || B_W != fracnet_mul_pkg::B_W) begin : g_bad_ab
      $error("fracnet_mul_share_sched: operand widths must match the DSP slice");
   end
   if (MUL_LAT < 2 || MUL_LAT > 4) begin : g_bad_lat
      $error("fracnet_mul_share_sched: MUL_LAT must be 2..4");
   end
   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != clog2(NUM_REQ)) begin : g_bad_req
      $error("fracnet_mul_share_sched: NUM_REQ must be 2..8 with ID_W=clog2(NUM_REQ)");
   end

   logic                  adv;
   logic                  xfer;
   logic [NUM_REQ-1:0]    gnt;
   logic [ID_W-1:0]       gidx;
   logic [ID_W-1:0]       ptr_reg, ptr_next;
   logic signed [A_W-1:0] a_arr [NUM_REQ];
   logic signed [B_W-1:0] b_arr [NUM_REQ];
   mul_op_t               s0_reg, s0_next;
   logic signed [P_W-1:0] prod;
   logic signed [P_W-1:0] p_reg  [MUL_LAT-1];
   logic [ID_W-1:0]       id_reg [MUL_LAT-1];
   logic [MUL_LAT-2:0]    v_reg;
   logic                  id_unused;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*A_W +: A_W];
      assign b_arr[gi] = req_b[gi*B_W +: B_W];
   end

   // The output stage gates everything: if it is empty or being taken, all
   // stages shift together.
   assign adv = !rsp_valid || rsp_ready;

   // Reset gates the enable so no requester sees ready while held in reset.
   fracnet_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_reg),
      .en  (adv && ap_rst_n),
      .gnt (gnt),
      .idx (gidx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   always_comb begin
      s0_next              = '0;
      s0_next.a            = a_arr[gidx];
      s0_next.b            = b_arr[gidx];
      s0_next.id[ID_W-1:0] = gidx;
      s0_next.vld          = xfer;
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (xfer) begin
         ptr_next = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
      end
   end

   // Full-width signed product; sign-extend operands first so the multiply is
   // evaluated at P_W and maps onto the DSP's signed mode.
   assign prod = P_W'($signed(s0_reg.a)) * P_W'($signed(s0_reg.b));

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ptr_reg <= '0;
         s0_reg  <= '0;
         v_reg   <= '0;
         for (int k = 0; k < MUL_LAT-1; k++) begin
            p_reg[k]  <= '0;
            id_reg[k] <= '0;
         end
      end else begin
         ptr_reg <= ptr_next;
         if (adv) begin
            s0_reg    <= s0_next;
            p_reg[0]  <= prod;
            id_reg[0] <= s0_reg.id[ID_W-1:0];
            v_reg[0]  <= s0_reg.vld;
            for (int k = 1; k < MUL_LAT-1; k++) begin
               p_reg[k]  <= p_reg[k-1];
               id_reg[k] <= id_reg[k-1];
               v_reg[k]  <= v_reg[k-1];
            end
         end
      end
   end

   // Upper id bits are zero padding when fewer than 8 requesters exist.
   assign id_unused = ^s0_reg.id;

   assign rsp_valid = v_reg[MUL_LAT-2];
   assign rsp_p     = p_reg[MUL_LAT-2];
   assign rsp_id    = id_reg[MUL_LAT-2];
   assign busy      = s0_reg.vld || (|v_reg);

endmodule

// File: tb/tb_fracnet_mul_share_sched.sv
// -----------------------------------------------------------------------------
// tb_fracnet_mul_share_sched
// Self-checking bench: a behavioural model (round-robin search from a pointer,
// a fixed-latency delay line that freezes when the output is held) predicts
// ready, response and busy every cycle; directed vectors and sequences cover
// single ops, arithmetic extremes, wrap/skip, fairness, stall and reset.
// -----------------------------------------------------------------------------
module tb_fracnet_mul_share_sched;

   localparam int N = 4;
   localparam int L = 2;

   logic          clk;
   logic          ap_rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*16-1:0] req_a;
   logic [N*12-1:0] req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [27:0]   rsp_p;
   logic [1:0]    rsp_id;
   logic          busy;

   logic signed [15:0] op_a [N];
   logic signed [11:0] op_b [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_a[gi*16 +: 16] = op_a[gi];
      assign req_b[gi*12 +: 12] = op_b[gi];
   end

   fracnet_mul_share_sched dut (
      .ap_clk    (clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic   vld;
      longint p;
      int     id;
   } stg_t;

   typedef struct {
      int                 idx;
      logic signed [15:0] a;
      logic signed [11:0] b;
      longint             exp_p;
   } vec_t;

   stg_t mp [L];
   int   mptr;
   int   tests;
   int   fails;

   logic [N-1:0]       s_ready;
   logic               s_rv;
   logic signed [27:0] s_p;
   logic [1:0]         s_id;
   logic               s_busy;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      mptr = 0;
      for (int k = 0; k < L; k++) mp[k] = '{1'b0, 0, 0};
   endtask

   function automatic logic pipe_busy();
      logic any;
      any = 1'b0;
      for (int k = 0; k < L; k++) any |= mp[k].vld;
      return any;
   endfunction

   task automatic new_op(input int i);
      op_a[i] = 16'($urandom);
      op_b[i] = 12'($urandom);
      if ($urandom_range(7) == 0) op_a[i] = 16'h8000;
      if ($urandom_range(7) == 0) op_b[i] = 12'h800;
      req_valid[i] = 1'b1;
   endtask

   // One clock: sample and compare at the falling edge, advance the model at
   // the rising edge, then retire/refill the granted requester.
   task automatic cycle(input logic [N-1:0] refill);
      int       mg;
      int       j;
      logic     madv;
      logic [N-1:0] eg;
      @(negedge clk);
      s_ready = req_ready;
      s_rv    = rsp_valid;
      s_p     = rsp_p;
      s_id    = rsp_id;
      s_busy  = busy;
      madv = !mp[L-1].vld || rsp_ready;
      mg   = -1;
      if (madv) begin
         for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (mg < 0 && req_valid[j]) mg = j;
         end
      end
      eg = '0;
      if (mg >= 0) eg[mg] = 1'b1;
      chk("req_ready", s_ready, eg);
      chk("rsp_valid", s_rv, mp[L-1].vld);
      if (mp[L-1].vld) begin
         chk("rsp_p", s_p, mp[L-1].p);
         chk("rsp_id", s_id, mp[L-1].id);
      end
      chk("busy", s_busy, pipe_busy());
      @(posedge clk);
      if (madv) begin
         for (int k = L-1; k > 0; k--) mp[k] = mp[k-1];
         mp[0] = '{1'b0, 0, 0};
         if (mg >= 0) begin
            mp[0].vld = 1'b1;
            mp[0].id  = mg;
            mp[0].p   = longint'(op_a[mg]) * longint'(op_b[mg]);
         end
      end
      if (mg >= 0) mptr = (mg + 1) % N;
      #1;
      if (mg >= 0) begin
         req_valid[mg] = 1'b0;
         if (refill[mg]) new_op(mg);
      end
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         rsp_ready = 1'b1;
         if (req_valid == '0 && !pipe_busy()) done = 1'b1;
         else cycle('0);
      end
      chk("drain_bound", done, 1);
   endtask

   vec_t vt [5];
   logic [N-1:0]       one;
   logic signed [27:0] p0;
   logic [1:0]         id0;

   initial begin
      tests = 0;
      fails = 0;
      vt[0] = '{0, 16'sd3,   -12'sd5,  -15};
      vt[1] = '{1, 16'h8000, 12'h800,  67108864};
      vt[2] = '{2, 16'h7FFF, 12'h800,  -67106816};
      vt[3] = '{3, 16'sd0,   12'sd2047, 0};
      vt[4] = '{1, -16'sd1,  -12'sd1,  1};

      // Reset state, with every requester asserting valid during reset.
      ap_rst_n  = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      for (int i = 0; i < N; i++) new_op(i);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      req_valid = '0;
      ap_rst_n  = 1'b1;

      // Single ops, including arithmetic extremes; last entry leaves ptr at 2.
      for (int v = 0; v < 5; v++) begin
         op_a[vt[v].idx]      = vt[v].a;
         op_b[vt[v].idx]      = vt[v].b;
         req_valid[vt[v].idx] = 1'b1;
         one = 4'b0001 << vt[v].idx;
         cycle('0);
         chk("tbl_grant", s_ready, one);
         cycle('0);
         chk("tbl_early", s_rv, 0);
         cycle('0);
         chk("tbl_valid", s_rv, 1);
         chk("tbl_p", s_p, vt[v].exp_p);
         chk("tbl_id", s_id, vt[v].idx);
      end
      drain();

      // Wrap/skip: only 3 and 1 valid with ptr=2.
      new_op(3);
      new_op(1);
      cycle('0);
      chk("t4_first", s_ready, 4'b1000);
      cycle('0);
      chk("t4_second", s_ready, 4'b0010);
      for (int i = 0; i < N; i++) if (!req_valid[i]) new_op(i);
      cycle('0);
      chk("t4_ptr_after", s_ready, 4'b0100);
      drain();

      // Reset with two ops in flight.
      new_op(0);
      new_op(1);
      cycle('0);
      cycle('0);
      chk("t6_inflight", busy, 1);
      ap_rst_n = 1'b0;
      #1;
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_busy", busy, 0);
      model_reset();
      req_valid = '0;
      @(posedge clk);
      #1;
      ap_rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle('0);
         chk("t6_no_stale", s_rv, 0);
      end

      // Fairness with all requesters continuously valid, ptr=0 after reset.
      for (int i = 0; i < N; i++) new_op(i);
      rsp_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cycle(4'hF);
         one = 4'b0001 << (k % 4);
         chk("t2_grant", s_ready, one);
         if (k >= 2) begin
            chk("t2_rsp_valid", s_rv, 1);
            chk("t2_rsp_id", s_id, (k - 2) % 4);
         end
      end

      // Stall for 5 cycles with a full pipeline.
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle(4'hF);
         if (k == 0) begin
            p0  = s_p;
            id0 = s_id;
         end else begin
            chk("t3_p_hold", s_p, p0);
            chk("t3_id_hold", s_id, id0);
         end
         chk("t3_ready_zero", s_ready, 0);
         chk("t3_valid_hold", s_rv, 1);
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) cycle(4'hF);
      drain();

      // Randomised traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         rsp_ready = ($urandom_range(3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(1) == 1) new_op(i);
         end
         cycle('0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
